// File: rtl/traffic_lights_pkg.sv
// ---------------------------------------------------------------------------
// traffic_lights_pkg
// Shared types and helpers for the traffic_lights command path.
//   cmd_type_t : 3-bit command code driven on cmd_type
//   mode_t     : controller mode as tracked by the command master
//   CMD_TYPE_W / CMD_DATA_W : widths of the command code and payload
//   is_set_time()      : code carries a duration payload (SET_GREEN/RED/YELLOW)
//   is_illegal_code()  : code has no meaning to traffic_lights
// ---------------------------------------------------------------------------
package traffic_lights_pkg;

   localparam int CMD_TYPE_W = 3;
   localparam int CMD_DATA_W = 16;

   typedef enum logic [2:0] {
      CMD_ON         = 3'd0,
      CMD_OFF        = 3'd1,
      CMD_UNMANAGED  = 3'd2,
      CMD_SET_GREEN  = 3'd3,
      CMD_SET_RED    = 3'd4,
      CMD_SET_YELLOW = 3'd5,
      CMD_ILLEGAL_6  = 3'd6,
      CMD_ILLEGAL_7  = 3'd7
   } cmd_type_t;

   typedef enum logic [1:0] {
      MODE_OFF       = 2'd0,
      MODE_ON        = 2'd1,
      MODE_UNMANAGED = 2'd2
   } mode_t;

   function automatic logic is_set_time(input cmd_type_t code);
      return (code == CMD_SET_GREEN) || (code == CMD_SET_RED) || (code == CMD_SET_YELLOW);
   endfunction

   function automatic logic is_illegal_code(input cmd_type_t code);
      return (code == CMD_ILLEGAL_6) || (code == CMD_ILLEGAL_7);
   endfunction

endpackage

// File: rtl/traffic_lights_cmd_fifo.sv
// ---------------------------------------------------------------------------
// traffic_lights_cmd_fifo
// Small synchronous FIFO buffering accepted command requests.
//   clk        : clock
//   rst_n      : asynchronous active-low reset (empties the FIFO)
//   push_i     : write wr_data_i (ignored when full)
//   wr_data_i  : entry to store
//   pop_i      : read the oldest entry (ignored when empty)
//   rd_data_o  : registered read data, updated on the edge that pops
//   full_o     : all DEPTH entries in use
//   empty_o    : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module traffic_lights_cmd_fifo
   import traffic_lights_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_TYPE_W + CMD_DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             do_push;
   logic             do_pop;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = rd_data_q;

   // Pointer and occupancy bookkeeping; a push and pop in the same cycle
   // leave the count unchanged.
   always_comb begin
      wr_ptr_d  = wr_ptr_q + AW'(do_push);
      rd_ptr_d  = rd_ptr_q + AW'(do_pop);
      count_d   = count_q + CW'(do_push) - CW'(do_pop);
      rd_data_d = rd_data_q;
      if (do_pop) begin
         rd_data_d = mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage array carries no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/traffic_lights_cmd_master.sv
// ---------------------------------------------------------------------------
// traffic_lights_cmd_master
// Issues commands to traffic_lights. Host requests are validated against a
// shadow copy of the controller mode, queued, and emitted as single-cycle
// cmd_val_o strobes separated by a guaranteed idle gap.
//   clk_0m002    : clock
//   arst_n_i     : asynchronous active-low reset (deassertion synchronised here)
//   req_type_i   : requested command code
//   req_data_i   : request payload (milliseconds for set-time codes)
//   req_val_i    : request valid
//   req_ready_o  : request ready (low when the queue is full or in reset)
//   cmd_type_o   : command code to traffic_lights (holds last issued value)
//   cmd_data_o   : payload to traffic_lights (holds last issued value)
//   cmd_val_o    : one-cycle command strobe
//   mode_o       : shadow mode (0 OFF, 1 ON, 2 UNMANAGED), reflects queued state
//   busy_o       : queue non-empty or issue sequencer active
//   drop_cnt_o   : saturating count of rejected requests
// ---------------------------------------------------------------------------
module traffic_lights_cmd_master
   import traffic_lights_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int MIN_GAP_CYCLES = 3,
   parameter int DROP_CNT_W     = 8
) (
   input  logic                  clk_0m002,
   input  logic                  arst_n_i,
   input  logic [CMD_TYPE_W-1:0] req_type_i,
   input  logic [CMD_DATA_W-1:0] req_data_i,
   input  logic                  req_val_i,
   output logic                  req_ready_o,
   output logic [CMD_TYPE_W-1:0] cmd_type_o,
   output logic [CMD_DATA_W-1:0] cmd_data_o,
   output logic                  cmd_val_o,
   output logic [1:0]            mode_o,
   output logic                  busy_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);

   localparam int GAP_W    = $clog2(MIN_GAP_CYCLES + 1);
   localparam int ENTRY_W  = CMD_TYPE_W + CMD_DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   logic [1:0]            rst_sync_q, rst_sync_d;
   logic                  rst_n;

   state_t                state_q, state_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic                  cmd_val_q, cmd_val_d;
   logic [CMD_TYPE_W-1:0] cmd_type_q, cmd_type_d;
   logic [CMD_DATA_W-1:0] cmd_data_q, cmd_data_d;
   mode_t                 mode_q, mode_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic                  busy_q, busy_d;

   cmd_type_t             req_code;
   logic                  accept;
   logic                  req_reject;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ENTRY_W-1:0]    fifo_rd_data;

   // Reset assertion reaches every flop immediately through the async clear;
   // release is delayed by two clock edges so all state leaves reset together.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   // Ready is held low while the block is in reset so that no request is
   // handshaken and then silently lost.
   assign req_ready_o = rst_n && !fifo_full;
   assign accept      = req_val_i && req_ready_o;
   assign req_code    = cmd_type_t'(req_type_i);

   // Validation uses the shadow mode as left by all earlier accepted
   // requests, so checks follow acceptance order rather than issue order.
   always_comb begin
      req_reject = is_illegal_code(req_code) ||
                   (is_set_time(req_code) &&
                    ((mode_q != MODE_UNMANAGED) || (req_data_i == '0)));
      fifo_push  = accept && !req_reject;

      mode_d = mode_q;
      if (fifo_push) begin
         case (req_code)
            CMD_ON:        mode_d = MODE_ON;
            CMD_OFF:       mode_d = MODE_OFF;
            CMD_UNMANAGED: mode_d = MODE_UNMANAGED;
            default:       mode_d = mode_q;
         endcase
      end

      drop_d = drop_q;
      if (accept && req_reject && (drop_q != '1)) begin
         drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   traffic_lights_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk_0m002),
      .rst_n     (rst_n),
      .push_i    (fifo_push),
      .wr_data_i ({req_type_i, req_data_i}),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Issue sequencer. IDLE pops (FIFO read data is registered on that edge),
   // ISSUE loads the command registers and the strobe, GAP counts down the
   // idle spacing. The strobe is registered, so it is visible during the
   // first GAP cycle; together with IDLE and ISSUE this gives
   // MIN_GAP_CYCLES + 1 low cycles between back-to-back strobes.
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      cmd_val_d  = 1'b0;
      cmd_type_d = cmd_type_q;
      cmd_data_d = cmd_data_q;
      fifo_pop   = 1'b0;
      busy_d     = !fifo_empty || (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cmd_val_d  = 1'b1;
            cmd_type_d = fifo_rd_data[ENTRY_W-1:CMD_DATA_W];
            cmd_data_d = fifo_rd_data[CMD_DATA_W-1:0];
            gap_d      = GAP_W'(MIN_GAP_CYCLES);
            state_d    = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q <= GAP_W'(1)) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            gap_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_0m002 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gap_q      <= '0;
         cmd_val_q  <= 1'b0;
         cmd_type_q <= '0;
         cmd_data_q <= '0;
         mode_q     <= MODE_OFF;
         drop_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         cmd_val_q  <= cmd_val_d;
         cmd_type_q <= cmd_type_d;
         cmd_data_q <= cmd_data_d;
         mode_q     <= mode_d;
         drop_q     <= drop_d;
         busy_q     <= busy_d;
      end
   end

   assign cmd_val_o  = cmd_val_q;
   assign cmd_type_o = cmd_type_q;
   assign cmd_data_o = cmd_data_q;
   assign mode_o     = mode_q;
   assign busy_o     = busy_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_traffic_lights_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_traffic_lights_cmd_master
// Directed bench for traffic_lights_cmd_master: a table of single requests
// with hand-computed mode/drop/strobe expectations, plus hand-written
// sequences for latency, spacing, back-pressure, saturation and reset.
// ---------------------------------------------------------------------------
module tb_traffic_lights_cmd_master;

   logic        clk_0m002 = 1'b0;
   logic        arst_n_i  = 1'b0;
   logic [2:0]  req_type_i = '0;
   logic [15:0] req_data_i = '0;
   logic        req_val_i  = 1'b0;
   logic        req_ready_o;
   logic [2:0]  cmd_type_o;
   logic [15:0] cmd_data_o;
   logic        cmd_val_o;
   logic [1:0]  mode_o;
   logic        busy_o;
   logic [7:0]  drop_cnt_o;

   traffic_lights_cmd_master #(
      .FIFO_DEPTH     (4),
      .MIN_GAP_CYCLES (3),
      .DROP_CNT_W     (8)
   ) dut (
      .clk_0m002   (clk_0m002),
      .arst_n_i    (arst_n_i),
      .req_type_i  (req_type_i),
      .req_data_i  (req_data_i),
      .req_val_i   (req_val_i),
      .req_ready_o (req_ready_o),
      .cmd_type_o  (cmd_type_o),
      .cmd_data_o  (cmd_data_o),
      .cmd_val_o   (cmd_val_o),
      .mode_o      (mode_o),
      .busy_o      (busy_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   always #5 clk_0m002 = ~clk_0m002;

   typedef struct {
      logic [2:0]  typ;
      logic [15:0] data;
      logic        legal;
      logic [1:0]  exp_mode;
      logic [7:0]  exp_drop;
   } vec_t;

   vec_t        vecs [10];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          npulse = 0;
   int          pulse_cyc  [64];
   logic [2:0]  pulse_type [64];
   logic [15:0] pulse_data [64];

   // One clock: sample #1 after the rising edge and log any strobe.
   task automatic sampleTick();
      @(posedge clk_0m002);
      #1;
      cyc++;
      if (cmd_val_o && (npulse < 64)) begin
         pulse_cyc[npulse]  = cyc;
         pulse_type[npulse] = cmd_type_o;
         pulse_data[npulse] = cmd_data_o;
         npulse++;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Present one request, wait (bounded) for ready, complete the handshake.
   task automatic applyStimulus(input logic [2:0] typ, input logic [15:0] data,
                                output int acc_cyc);
      int g;
      req_type_i = typ;
      req_data_i = data;
      req_val_i  = 1'b1;
      g = 0;
      while (!req_ready_o && (g < 50)) begin
         sampleTick();
         g++;
      end
      checkOutput("ready before push", 32'(req_ready_o), 32'd1);
      sampleTick();
      acc_cyc   = cyc;
      req_val_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      int k;
      int g;
      int idx;
      logic rdy;
      logic saw_full;

      // typ, data, legal, mode after, drop after (starting in UNMANAGED, drop 0)
      vecs[0] = '{3'd3, 16'd500,   1'b1, 2'd2, 8'd0};
      vecs[1] = '{3'd4, 16'd0,     1'b0, 2'd2, 8'd1};
      vecs[2] = '{3'd7, 16'd5,     1'b0, 2'd2, 8'd2};
      vecs[3] = '{3'd6, 16'd0,     1'b0, 2'd2, 8'd3};
      vecs[4] = '{3'd1, 16'd0,     1'b1, 2'd0, 8'd3};
      vecs[5] = '{3'd5, 16'd200,   1'b0, 2'd0, 8'd4};
      vecs[6] = '{3'd0, 16'd0,     1'b1, 2'd1, 8'd4};
      vecs[7] = '{3'd3, 16'd100,   1'b0, 2'd1, 8'd5};
      vecs[8] = '{3'd2, 16'd7,     1'b1, 2'd2, 8'd5};
      vecs[9] = '{3'd5, 16'd65535, 1'b1, 2'd2, 8'd5};

      // ---- reset state ----
      repeat (3) sampleTick();
      checkOutput("reset ready",  32'(req_ready_o), 32'd0);
      checkOutput("reset val",    32'(cmd_val_o),   32'd0);
      checkOutput("reset mode",   32'(mode_o),      32'd0);
      checkOutput("reset busy",   32'(busy_o),      32'd0);
      checkOutput("reset drop",   32'(drop_cnt_o),  32'd0);
      checkOutput("reset type",   32'(cmd_type_o),  32'd0);
      arst_n_i = 1'b1;
      repeat (3) sampleTick();
      checkOutput("post-reset ready", 32'(req_ready_o), 32'd1);

      // ---- first command latency ----
      npulse = 0;
      applyStimulus(3'd2, 16'd9, acc);
      checkOutput("t1 mode after accept", 32'(mode_o), 32'd2);
      sampleTick();
      checkOutput("t1 val at k+1", 32'(cmd_val_o), 32'd0);
      sampleTick();
      checkOutput("t1 val at k+2",  32'(cmd_val_o),  32'd1);
      checkOutput("t1 type",        32'(cmd_type_o), 32'd2);
      checkOutput("t1 data",        32'(cmd_data_o), 32'd9);
      sampleTick();
      checkOutput("t1 val at k+3",  32'(cmd_val_o),  32'd0);
      checkOutput("t1 type held",   32'(cmd_type_o), 32'd2);
      repeat (8) sampleTick();
      checkOutput("t1 busy idle",   32'(busy_o),     32'd0);

      // ---- table of single requests ----
      for (int i = 0; i < 10; i++) begin
         npulse = 0;
         applyStimulus(vecs[i].typ, vecs[i].data, acc);
         checkOutput($sformatf("vec%0d mode", i), 32'(mode_o),     32'(vecs[i].exp_mode));
         checkOutput($sformatf("vec%0d drop", i), 32'(drop_cnt_o), 32'(vecs[i].exp_drop));
         repeat (8) sampleTick();
         checkOutput($sformatf("vec%0d pulses", i), 32'(npulse), vecs[i].legal ? 32'd1 : 32'd0);
         if (vecs[i].legal && (npulse > 0)) begin
            checkOutput($sformatf("vec%0d latency", i), 32'(pulse_cyc[0] - acc), 32'd2);
            checkOutput($sformatf("vec%0d type", i), 32'(pulse_type[0]), 32'(vecs[i].typ));
            checkOutput($sformatf("vec%0d data", i), 32'(pulse_data[0]), 32'(vecs[i].data));
         end
         checkOutput($sformatf("vec%0d busy", i), 32'(busy_o), 32'd0);
      end

      // ---- back-to-back set-time commands in UNMANAGED ----
      npulse = 0;
      req_val_i  = 1'b1;
      req_type_i = 3'd3; req_data_i = 16'd500;
      sampleTick();
      k = cyc;
      req_type_i = 3'd4; req_data_i = 16'd1000;
      sampleTick();
      req_type_i = 3'd5; req_data_i = 16'd200;
      sampleTick();
      req_val_i = 1'b0;
      g = 0;
      while ((npulse < 3) && (g < 40)) begin
         sampleTick();
         g++;
      end
      checkOutput("b2b pulses",   32'(npulse), 32'd3);
      checkOutput("b2b latency",  32'(pulse_cyc[0] - k), 32'd2);
      checkOutput("b2b spacing1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);
      checkOutput("b2b spacing2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);
      checkOutput("b2b type0", 32'(pulse_type[0]), 32'd3);
      checkOutput("b2b data0", 32'(pulse_data[0]), 32'd500);
      checkOutput("b2b type1", 32'(pulse_type[1]), 32'd4);
      checkOutput("b2b data1", 32'(pulse_data[1]), 32'd1000);
      checkOutput("b2b type2", 32'(pulse_type[2]), 32'd5);
      checkOutput("b2b data2", 32'(pulse_data[2]), 32'd200);
      repeat (8) sampleTick();
      checkOutput("b2b drop", 32'(drop_cnt_o), 32'd5);

      // ---- back-pressure: six ON/OFF requests into a depth-4 queue ----
      npulse   = 0;
      saw_full = 1'b0;
      idx      = 0;
      g        = 0;
      req_val_i = 1'b1;
      while ((idx < 6) && (g < 100)) begin
         req_type_i = 3'(idx % 2);
         req_data_i = 16'h0100 + 16'(idx);
         rdy = req_ready_o;
         if (!rdy) saw_full = 1'b1;
         sampleTick();
         if (rdy) idx++;
         g++;
      end
      req_val_i = 1'b0;
      checkOutput("full accepted", 32'(idx), 32'd6);
      checkOutput("full ready low seen", 32'(saw_full), 32'd1);
      g = 0;
      while ((npulse < 6) && (g < 200)) begin
         sampleTick();
         g++;
      end
      checkOutput("full pulses", 32'(npulse), 32'd6);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("full type%0d", i), 32'(pulse_type[i]), 32'(i % 2));
         checkOutput($sformatf("full data%0d", i), 32'(pulse_data[i]), 32'h100 + 32'(i));
      end
      g = 0;
      while ((cyc < pulse_cyc[5] + 3) && (g < 10)) begin
         sampleTick();
         g++;
      end
      checkOutput("full busy at gap end", 32'(busy_o), 32'd1);
      sampleTick();
      checkOutput("full busy after gap",  32'(busy_o), 32'd0);
      checkOutput("full mode", 32'(mode_o), 32'd0);

      // ---- drop counter saturation ----
      npulse = 0;
      req_val_i  = 1'b1;
      req_type_i = 3'd7;
      req_data_i = 16'd0;
      repeat (249) sampleTick();
      checkOutput("drop at 254", 32'(drop_cnt_o), 32'd254);
      repeat (51) sampleTick();
      req_val_i = 1'b0;
      checkOutput("drop saturated", 32'(drop_cnt_o), 32'd255);
      sampleTick();
      checkOutput("drop no pulses", 32'(npulse), 32'd0);
      checkOutput("drop busy", 32'(busy_o), 32'd0);

      // ---- reset while a strobe is high with two entries queued ----
      npulse = 0;
      req_val_i  = 1'b1;
      req_type_i = 3'd0; req_data_i = 16'd1;
      sampleTick();
      req_type_i = 3'd1; req_data_i = 16'd2;
      sampleTick();
      req_type_i = 3'd0; req_data_i = 16'd3;
      sampleTick();
      req_val_i = 1'b0;
      checkOutput("rst pre val",  32'(cmd_val_o),  32'd1);
      checkOutput("rst pre data", 32'(cmd_data_o), 32'd1);
      checkOutput("rst pre mode", 32'(mode_o),     32'd1);
      #2;
      arst_n_i = 1'b0;
      #1;
      checkOutput("rst val async",   32'(cmd_val_o),   32'd0);
      checkOutput("rst ready async", 32'(req_ready_o), 32'd0);
      checkOutput("rst mode async",  32'(mode_o),      32'd0);
      repeat (2) sampleTick();
      arst_n_i = 1'b1;
      npulse = 0;
      repeat (20) sampleTick();
      checkOutput("rst post pulses", 32'(npulse),      32'd0);
      checkOutput("rst post mode",   32'(mode_o),      32'd0);
      checkOutput("rst post busy",   32'(busy_o),      32'd0);
      checkOutput("rst post ready",  32'(req_ready_o), 32'd1);
      checkOutput("rst post drop",   32'(drop_cnt_o),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_lights_cmd_master.md
Name: traffic_lights_cmd_master

Overview:
Command-issuing end of the traffic_lights command interface (cmd_type/cmd_val/cmd_data).
- Accepts host requests over a valid/ready handshake and validates them against a shadow copy of the controller mode.
- Buffers accepted requests in a small FIFO and emits single-cycle cmd_val pulses, spaced by a guaranteed idle gap.
- Sits between a host/CSR block and traffic_lights in the clk_0m002 domain.

Parameters:
- FIFO_DEPTH, 4, request buffer entries; power of two, >= 2.
- MIN_GAP_CYCLES, 3, minimum idle (cmd_val_o low) cycles between consecutive cmd_val_o pulses; >= 1.
- DROP_CNT_W, 8, width of the saturating rejected-request counter.

Ports:
- clk_0m002  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- req_type_i  in  3  requested command code.
- req_data_i  in  16  command payload (time in ms for set-time codes).
- req_val_i  in  1  request valid.
- req_ready_o  out  1  request ready; handshake completes on a rising edge with req_val_i && req_ready_o.
- cmd_type_o  out  3  command code to traffic_lights.
- cmd_data_o  out  16  payload to traffic_lights.
- cmd_val_o  out  1  one-cycle command strobe.
- mode_o  out  2  shadow mode: 0 OFF, 1 ON, 2 UNMANAGED.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.
- drop_cnt_o  out  DROP_CNT_W  rejected requests, saturating.

Behaviour:
- Reset (async assert, sync deassert inside the block): all outputs 0, FIFO empty, FSM IDLE, mode_o = OFF, gap counter 0.
- Command codes (fixed):
  - 0 ON; 1 OFF; 2 UNMANAGED.
  - 3 SET_GREEN; 4 SET_RED; 5 SET_YELLOW.
  - 6 and 7 are illegal.
- req_ready_o = !fifo_full. Requests are never accepted while the FIFO is full; no push-on-pop bypass.
- Validation happens at the accepting edge, in acceptance order. A request is rejected (handshake still completes, nothing stored, drop_cnt_o += 1, saturating at all-ones) when any of these hold:
  - the code is 6 or 7;
  - the code is 3–5 and mode_o != UNMANAGED;
  - the code is 3–5 and req_data_i == 0.
- Shadow mode updates on each accepted, valid request: 0 -> ON, 1 -> OFF, 2 -> UNMANAGED; codes 3–5 leave it unchanged. mode_o therefore reflects queued state, not yet-issued state.
- FSM states:
  - IDLE: if FIFO non-empty, pop -> ISSUE.
  - ISSUE (1 cycle): cmd_val_o = 1; cmd_type_o/cmd_data_o = popped entry; load gap counter with MIN_GAP_CYCLES -> GAP.
  - GAP: decrement each cycle; at 0 -> IDLE.
- cmd_type_o/cmd_data_o are registered and hold their last issued value outside ISSUE. cmd_val_o is high only in ISSUE.
- Latency: request accepted at edge k with empty FIFO and FSM IDLE -> cmd_val_o high for exactly the cycle after edge k+2.
- Back-to-back spacing: pulses are separated by exactly MIN_GAP_CYCLES + 1 low cycles when the queue is continuously non-empty (GAP plus the IDLE pop cycle).
- Simultaneous enqueue and dequeue in one cycle are allowed when not full; the occupancy count is unchanged.
- Reset asserted mid-operation: the FIFO is flushed, cmd_val_o drops immediately (async), and no partial pulse occurs after release.

Decomposition:
- Package traffic_lights_pkg holds:
  - typedef cmd_type_t (3-bit enum, codes 0–7 as above);
  - typedef mode_t (2-bit enum OFF/ON/UNMANAGED);
  - localparam CMD_DATA_W = 16;
  - function is_set_time(cmd_type_t).
- Sub-module traffic_lights_cmd_fifo: synchronous FIFO, width 3+16, depth FIFO_DEPTH, async active-low reset, full/empty flags, first-word registered read on pop.

Test Plan:
- Reset, then req type 2 at edge 5 -> cmd_val_o=1 in cycle after edge 7, cmd_type_o=2, mode_o=2 after edge 5.
- In UNMANAGED: push 3/500, 4/1000, 5/200 back-to-back, MIN_GAP_CYCLES=3 -> three pulses in that order, each pair 4 low cycles apart, data matches.
- From OFF: push type 3 data 500 -> accepted, no pulse, drop_cnt_o=1. Push type 7 -> drop_cnt_o=2. Push type 4 data 0 in UNMANAGED -> drop_cnt_o=3.
- Hold req_val_i high with 6 valid type 0/1 requests, depth 4 -> req_ready_o low after 4 stored; all 6 eventually issued in order; busy_o falls 1 cycle after the last GAP ends.
- Force 300 illegal requests with DROP_CNT_W=8 -> drop_cnt_o saturates at 255.
- Assert arst_n_i low during ISSUE with 2 entries queued -> cmd_val_o low immediately; after release: no pulses, mode_o=0, busy_o=0, req_ready_o=1.
